// File: rtl/block_sum_accumulator_pkg.sv
// Shared definitions for the block sum accumulator: operand width, FSM
// encoding and the packed result record held by the top block.
package block_sum_accumulator_pkg;

    localparam int DATA_W      = 32;
    localparam int CARRY_MAX_W = 16;
    localparam int COUNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // carry is sized for the widest counter; only the low CARRY_W bits are ever non-zero
    typedef struct packed {
        logic [CARRY_MAX_W-1:0] carry;
        logic [DATA_W-1:0]      sum;
        logic [COUNT_W-1:0]     count;
        logic                   ovf;
    } result_t;

    function automatic logic [CARRY_MAX_W-1:0] carry_max(input int width);
        return CARRY_MAX_W'((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/Carryincadder.sv
// 32-bit carry-increment adder: 4-bit groups add with carry-in 0, then the
// incoming group carry increments the partial sum and propagates on all-ones.
module Carryincadder
    import block_sum_accumulator_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_c0,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_cout
);

    localparam int GROUPS = DATA_W / 4;

    logic [GROUPS:0] w_c;

    assign w_c[0] = i_c0;

    for (genvar k = 0; k < GROUPS; k++) begin : g_group
        logic [4:0] w_raw;
        assign w_raw         = {1'b0, i_a[4*k +: 4]} + {1'b0, i_b[4*k +: 4]};
        assign o_sum[4*k +: 4] = w_raw[3:0] + {3'b000, w_c[k]};
        assign w_c[k+1]      = w_raw[4] | (w_c[k] & (&w_raw[3:0]));
    end

    assign o_cout = w_c[GROUPS];

endmodule

// File: rtl/block_sum_accumulator.sv
// Folds a stream of 32-bit operands into a running sum through the carry-increment
// adder, counting carry-outs, and emits one result per block of BLOCK_LEN operands or in_last.
module block_sum_accumulator
    import block_sum_accumulator_pkg::*;
#(
    parameter int BLOCK_LEN = 16,
    parameter int CARRY_W   = 8
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [DATA_W-1:0]  i_in_data,
    input  logic               i_in_last,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [DATA_W-1:0]  o_out_sum,
    output logic [CARRY_W-1:0] o_out_carry,
    output logic [COUNT_W-1:0] o_out_count,
    output logic               o_out_ovf
);

    localparam logic [1:0]             ST_IDLE   = IDLE;
    localparam logic [1:0]             ST_ACC    = ACC;
    localparam logic [1:0]             ST_OUT    = OUT;
    localparam logic [COUNT_W-1:0]     LEN_C     = COUNT_W'(BLOCK_LEN);
    localparam logic [CARRY_MAX_W-1:0] CARRY_TOP = carry_max(CARRY_W);

    logic [1:0]        r_state;
    result_t           r_res;
    logic              r_out_valid;
    logic              r_in_ready;

    result_t           w_next;
    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic              w_xfer;
    logic              w_close;
    logic              w_hs;

    Carryincadder u_adder (
        .i_a    (r_res.sum),
        .i_b    (i_in_data),
        .i_c0   (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_xfer  = i_in_valid & r_in_ready;
    assign w_hs    = r_out_valid & i_out_ready;
    assign w_close = i_in_last | (w_next.count == LEN_C);

    // Accumulator update applied on an operand transfer; carry saturates and flags ovf
    always_comb begin
        w_next       = r_res;
        w_next.sum   = w_sum;
        w_next.count = r_res.count + 8'd1;
        if (w_cout) begin
            if (r_res.carry == CARRY_TOP) begin
                w_next.ovf = 1'b1;
            end else begin
                w_next.carry = r_res.carry + 16'd1;
            end
        end else begin
            w_next.carry = r_res.carry;
        end
    end

    // Block FSM with accumulator, handshake flags and clear taking priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else if (i_clear) begin
            r_state     <= ST_IDLE;
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACC: begin
                    if (w_xfer) begin
                        r_res <= w_next;
                        if (w_close) begin
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state    <= ST_ACC;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (w_hs) begin
                        r_state     <= ST_IDLE;
                        r_res       <= '0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_in_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_res       <= '0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_res.sum;
    assign o_out_carry = r_res.carry[CARRY_W-1:0];
    assign o_out_count = r_res.count;
    assign o_out_ovf   = r_res.ovf;

endmodule

// File: tb/tb_block_sum_accumulator.sv
// Scoreboard bench: two accumulators (CARRY_W=8 and CARRY_W=2) share one stimulus stream;
// a reference model pushes expected block results that are popped when each result appears.
module tb_block_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [31:0] in_data;

    logic        rdy_a, val_a, ovf_a, rdy_b, val_b, ovf_b;
    logic [31:0] sum_a, sum_b;
    logic [7:0]  carry_a, count_a, count_b;
    logic [1:0]  carry_b;

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  carry;
        logic [7:0]  count;
        logic        ovf;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          errors = 0;
    int          checks = 0;

    logic [31:0] m_sum;
    int          m_cnt, m_ca, m_cb;
    bit          m_oa, m_ob;

    always #5 clk = ~clk;

    block_sum_accumulator dut_a (
        .clk(clk), .rst_n(rst_n), .i_clear(clear),
        .i_in_valid(in_valid), .o_in_ready(rdy_a), .i_in_data(in_data), .i_in_last(in_last),
        .o_out_valid(val_a), .i_out_ready(out_ready),
        .o_out_sum(sum_a), .o_out_carry(carry_a), .o_out_count(count_a), .o_out_ovf(ovf_a)
    );

    block_sum_accumulator #(.BLOCK_LEN(16), .CARRY_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_clear(clear),
        .i_in_valid(in_valid), .o_in_ready(rdy_b), .i_in_data(in_data), .i_in_last(in_last),
        .o_out_valid(val_b), .i_out_ready(out_ready),
        .o_out_sum(sum_b), .o_out_carry(carry_b), .o_out_count(count_b), .o_out_ovf(ovf_b)
    );

    task automatic model_clear();
        m_sum = 32'd0; m_cnt = 0; m_ca = 0; m_cb = 0; m_oa = 1'b0; m_ob = 1'b0;
    endtask

    // Present one operand, wait (bounded) for acceptance, and update the reference model.
    task automatic send(input logic [31:0] d, input bit last);
        int          t;
        logic [32:0] s;
        exp_t        e;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; t = 0;
        while (rdy_a !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 40) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b required 1 within 40 cycles", rdy_a);
        end
        @(posedge clk);
        if (t < 40) begin
            s = {1'b0, m_sum} + {1'b0, d};
            m_sum = s[31:0];
            m_cnt++;
            if (s[32]) begin
                if (m_ca == 255) m_oa = 1'b1; else m_ca++;
                if (m_cb == 3)   m_ob = 1'b1; else m_cb++;
            end
            if (last || m_cnt == 16) begin
                e.sum = m_sum; e.carry = 8'(m_ca); e.count = 8'(m_cnt); e.ovf = m_oa;
                q_a.push_back(e);
                e.carry = 8'(m_cb); e.ovf = m_ob;
                q_b.push_back(e);
                model_clear();
            end
        end
    endtask

    // Wait (bounded) for out_valid; lat is 0 when valid at the first falling edge.
    task automatic wait_result(output bit ok, output int lat);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; lat = 0;
        while (val_a !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok = (val_a === 1'b1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_data = 32'd0;
        model_clear();
        #12;
        checks++;
        if ({val_a, rdy_a} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: valid,ready=%b required 00", {val_a, rdy_a});
        end
        checks++;
        if ({sum_a, carry_a, count_a, ovf_a} !== 49'd0) begin
            errors++;
            $display("FAIL reset_fields: sum=%h carry=%h count=%0d ovf=%b required all 0",
                     sum_a, carry_a, count_a, ovf_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", rdy_a);
        end
    endtask

    // Common result comparison for both instances after a wait.
    task automatic test_full_block();
        bit   ok;
        int   lat;
        exp_t ea, eb;
        for (int i = 0; i < 16; i++) send(32'hFFFF_FFFF, 1'b0);
        wait_result(ok, lat);
        checks++;
        if (!ok || lat != 0) begin
            errors++;
            $display("FAIL full_latency: valid after %0d cycles (ok=%b) required 0", lat, ok);
        end
        ea = q_a.pop_front(); eb = q_b.pop_front();
        checks++;
        if ({sum_a, carry_a, count_a, ovf_a} !== ea) begin
            errors++;
            $display("FAIL full_a: sum=%h carry=%h count=%0d ovf=%b required sum=%h carry=%h count=%0d ovf=%b",
                     sum_a, carry_a, count_a, ovf_a, ea.sum, ea.carry, ea.count, ea.ovf);
        end
        checks++;
        if ({sum_b, 6'd0, carry_b, count_b, ovf_b} !== eb) begin
            errors++;
            $display("FAIL full_sat_b: sum=%h carry=%h count=%0d ovf=%b required sum=%h carry=%h count=%0d ovf=%b",
                     sum_b, carry_b, count_b, ovf_b, eb.sum, eb.carry, eb.count, eb.ovf);
        end
        handshake();
        checks++;
        if (val_a !== 1'b0) begin
            errors++;
            $display("FAIL full_after_hs: out_valid=%b required 0", val_a);
        end
    endtask

    task automatic test_last();
        bit   ok;
        int   lat;
        exp_t ea;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        wait_result(ok, lat);
        ea = q_a.pop_front();
        void'(q_b.pop_front());
        checks++;
        if (!ok || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL last_ready: valid=%b in_ready=%b required valid 1 ready 0", val_a, rdy_a);
        end
        checks++;
        if ({sum_a, carry_a, count_a, ovf_a} !== ea) begin
            errors++;
            $display("FAIL last_result: sum=%h carry=%h count=%0d required sum=%h carry=%h count=%0d",
                     sum_a, carry_a, count_a, ea.sum, ea.carry, ea.count);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   lat;
        exp_t ea;
        send(32'h0000_000A, 1'b0);
        send(32'h0000_000B, 1'b1);
        wait_result(ok, lat);
        ea = q_a.pop_front();
        void'(q_b.pop_front());
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({sum_a, carry_a, count_a, ovf_a} !== ea || val_a !== 1'b1 || rdy_a !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b ready=%b sum=%h count=%0d required valid 1 ready 0 sum=%h count=%0d",
                         i, val_a, rdy_a, sum_a, count_a, ea.sum, ea.count);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        handshake();
        send(32'h0000_1234, 1'b1);
        wait_result(ok, lat);
        ea = q_a.pop_front();
        void'(q_b.pop_front());
        checks++;
        if (!ok || {sum_a, carry_a, count_a, ovf_a} !== ea) begin
            errors++;
            $display("FAIL after_hold: sum=%h count=%0d required sum=%h count=%0d",
                     sum_a, count_a, ea.sum, ea.count);
        end
        handshake();
    endtask

    task automatic test_boundary();
        bit   ok;
        int   lat;
        exp_t ea;
        for (int i = 1; i <= 16; i++) send(32'(i), i == 16);
        wait_result(ok, lat);
        ea = q_a.pop_front();
        void'(q_b.pop_front());
        checks++;
        if (!ok || {sum_a, carry_a, count_a, ovf_a} !== ea) begin
            errors++;
            $display("FAIL last_at_len: sum=%h count=%0d required sum=%h count=%0d",
                     sum_a, count_a, ea.sum, ea.count);
        end
        handshake();
        send(32'd5, 1'b0);
        send(32'd6, 1'b1);
        wait_result(ok, lat);
        ea = q_a.pop_front();
        void'(q_b.pop_front());
        checks++;
        if (!ok || {sum_a, carry_a, count_a, ovf_a} !== ea) begin
            errors++;
            $display("FAIL after_len: sum=%h count=%0d required sum=%h count=%0d",
                     sum_a, count_a, ea.sum, ea.count);
        end
        handshake();
    endtask

    task automatic test_clear();
        bit   ok;
        int   lat;
        exp_t ea;
        for (int i = 0; i < 5; i++) send(32'h10, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        model_clear();
        checks++;
        if ({val_a, rdy_a} !== 2'b01 || sum_a !== 32'd0 || count_a !== 8'd0) begin
            errors++;
            $display("FAIL clear_state: valid,ready=%b sum=%h count=%0d required 01, 0, 0",
                     {val_a, rdy_a}, sum_a, count_a);
        end
        for (int i = 0; i < 16; i++) send(32'h1, 1'b0);
        wait_result(ok, lat);
        ea = q_a.pop_front();
        void'(q_b.pop_front());
        checks++;
        if (!ok || {sum_a, carry_a, count_a, ovf_a} !== ea) begin
            errors++;
            $display("FAIL clear_fresh: sum=%h count=%0d required sum=%h count=%0d",
                     sum_a, count_a, ea.sum, ea.count);
        end
        clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b0;
        checks++;
        if (val_a !== 1'b0 || sum_a !== 32'd0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL clear_in_out: valid=%b sum=%h ready=%b required 0, 0, 1", val_a, sum_a, rdy_a);
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   lat;
        exp_t ea;
        for (int i = 0; i < 3; i++) send(32'h100, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({val_a, rdy_a} !== 2'b00 || sum_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_async: valid,ready=%b sum=%h required 00, 0", {val_a, rdy_a}, sum_a);
        end
        #1 rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 16; i++) send(32'h2, 1'b0);
        wait_result(ok, lat);
        ea = q_a.pop_front();
        void'(q_b.pop_front());
        checks++;
        if (!ok || {sum_a, carry_a, count_a, ovf_a} !== ea) begin
            errors++;
            $display("FAIL reset_mid_next: sum=%h count=%0d required sum=%h count=%0d",
                     sum_a, count_a, ea.sum, ea.count);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_last();
        test_backpressure();
        test_boundary();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/block_sum_accumulator.md
Name: block_sum_accumulator

Overview:
- Streaming consumer that sits directly downstream of the team's 32-bit carry-increment adder.
- Accepts a stream of 32-bit operands and folds each one into a running 32-bit sum through the adder.
- Counts the adder carry-outs into an extension field.
- Emits a {carry_count, sum} result once per block of BLOCK_LEN operands, or earlier if in_last is seen.

Parameters:
- BLOCK_LEN, 16, max operands per block (2..255).
- CARRY_W, 8, width of the saturating carry-out counter (1..16).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; discards the current block.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid & in_ready.
- in_data  in  32  operand.
- in_last  in  1  final operand of the block (qualified by the transfer).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_sum  out  32  low 32 bits of the block sum.
- out_carry  out  CARRY_W  number of adder carry-outs in the block, saturating.
- out_count  out  8  operands accepted in the block (1..BLOCK_LEN).
- out_ovf  out  1  set if out_carry saturated during the block.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; acc=0, carry=0, count=0, ovf=0.
  - out_valid=0, in_ready=0 while reset is asserted; in_ready=1 from the first cycle after release.
  - All result outputs read 0.
- Adder use:
  - One adder instance computes acc + in_data with c0=0.
  - The registered next acc is the adder sum; the adder cout drives the carry increment.
  - Adder path is combinational; a transfer updates acc in the same cycle (single-cycle accumulate, throughput 1 operand/clk).
- States:
  - IDLE: acc=0, carry=0, count=0. in_ready=1.
    - On transfer: acc<=in_data (adder with acc=0), count<=1, go to ACC.
    - If in_last or BLOCK_LEN==1, go to OUT instead.
  - ACC: in_ready=1.
    - On transfer: acc<=sum; count<=count+1; if cout, then carry<=carry+1, or hold at all-ones and set ovf when already all-ones.
    - Go to OUT when in_last=1 or count+1==BLOCK_LEN; otherwise stay.
    - No transfer: hold.
  - OUT: in_ready=0; out_valid=1; outputs driven from registers and stable until the handshake.
    - On out_ready: clear acc/carry/count/ovf, go to IDLE. No new operand accepted in that cycle.
- Latency: result valid the cycle after the closing operand transfer.
  - Block-to-block overhead: 1 OUT cycle (minimum) + 1 IDLE cycle is not required. The first operand of the next block can transfer in the cycle after the out handshake.
- Outputs are registered; out_valid never drops without a handshake except on clear or reset.
- clear=1:
  - Any state goes to IDLE next cycle with all registers zeroed.
  - A simultaneous input transfer is discarded.
  - A simultaneous output handshake is treated as not occurring.
  - clear has priority over every other event.
- in_last with count already at BLOCK_LEN-1: single transition to OUT, no double count.
- in_valid while in OUT: ignored (in_ready=0); upstream must hold.
- Reset mid-block: partial sum lost; no result emitted.

Decomposition:
- Shared package holds:
  - operand width constant DATA_W=32;
  - state enum {IDLE, ACC, OUT};
  - result struct {carry, sum, count, ovf}.
- One sub-module: the team's existing 32-bit carry-increment adder (Carryincadder), instantiated once with c0 tied low.
- FSM and counters stay in the top block.

Test Plan:
1. Sixteen operands of 0xFFFF_FFFF, no in_last, default parameters -> one result with out_sum=0xFFFF_FFF0, out_carry=0x0F, out_count=16, out_ovf=0, out_valid 1 cycle after the 16th transfer.
2. Operands 1, 2, 3 with in_last on the third -> out_sum=6, out_carry=0, out_count=3; in_ready=0 until the out handshake.
3. CARRY_W=2, sixteen operands of 0xFFFF_FFFF -> out_carry=3 (saturated), out_ovf=1, out_sum=0xFFFF_FFF0.
4. out_ready held low 5 cycles after the result -> out_valid and all output fields stable for 5 cycles, in_ready=0, no operand consumed; handshake then returns to IDLE, and the next block starts clean (first result equals the first operand alone).
5. clear asserted after 5 of 16 operands (each 0x10), then a fresh block of 0x1 x16 -> result out_sum=0x10, out_count=16; the aborted data never appears.
6. rst_n pulsed low asynchronously mid-ACC (between clock edges) -> out_valid and in_ready drop immediately; after release the next full block sums from zero.
